mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle unsigned multiply/divide controller that time-shares the 32-bit datapath ALU.
//  Runs iterative shift-add (MUL/MULHU) or restoring division (DIVU/REMU) as 32 ALU ADD/SUB steps.
//  Sits beside the ALU in the execute stage; the core stalls while busy=1 and takes result on done.
//  Shifts, carry/borrow detection and quotient bits are local; every add/subtract goes through the ALU.
// PARAMETERS
//  WIDTH    32      operand/ALU width; fixed at 32 to match the ALU
//  ALU_ADD  3'b000  alu_control code for add
//  ALU_SUB  3'b001  alu_control code for subtract
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   request; sampled only in IDLE
//  op           in   2   00 MUL (low 32), 01 MULHU (high 32), 10 DIVU, 11 REMU
//  operand_a    in   32  multiplicand / dividend, captured on accepted start
//  operand_b    in   32  multiplier / divisor, captured on accepted start
//  busy         out  1   high from cycle after accepted start until done cycle inclusive
//  done         out  1   one-cycle pulse, result valid
//  result       out  32  final result; held until next accepted start
//  alu_srcA     out  32  ALU operand A
//  alu_srcB     out  32  ALU operand B
//  alu_control  out  3   ALU operation select
//  alu_out      in   32  ALU result (combinational from alu_srcA/srcB/control)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, result=0, alu_srcA/B=0, alu_control=ALU_ADD,
//   all internal regs and iteration counter cleared; any in-flight op is discarded.
//  States: IDLE -> RUN (start=1) ; RUN -> DONE (counter==31 step) ; DONE -> IDLE (always).
//   DIVU/REMU with operand_b==0: IDLE -> DONE directly (fast path, no ALU use).
//  IDLE: start=1 latches op, operands; counter=0. In IDLE/DONE ALU outputs = 0/0/ALU_ADD.
//  MUL step (RUN, mul op): regs hi(32)=0, lo(32)=operand_b, m=operand_a at start.
//   alu_srcA=hi, alu_srcB=m, alu_control=ALU_ADD. If lo[0]=1: sum=alu_out, carry=(alu_out<hi) unsigned;
//   else sum=hi, carry=0. Then {hi,lo} <= {carry,sum,lo}>>1 (65-bit shift right by 1).
//  DIV step (RUN, div op): regs r(32)=0, q(32)=operand_a, d=operand_b at start.
//   sh={r,q[31]} (33 bits); alu_srcA=sh[31:0], alu_srcB=d, alu_control=ALU_SUB.
//   If sh[32]=1 or sh[31:0]>=d: r<=alu_out, qbit=1; else r<=sh[31:0], qbit=0. q<={q[30:0],qbit}.
//  Counter increments each RUN cycle; 32 RUN cycles exactly, wraps only via state exit.
//  DONE: done=1, busy=1, result <= MUL:lo, MULHU:hi, DIVU:q, REMU:r (registered, visible in DONE cycle).
//  Divide-by-zero: DIVU result=32'hFFFFFFFF, REMU result=operand_a (RISC-V semantics).
//  Latency: start accepted at edge 0 -> done high in cycle 33 (after 32 RUN cycles); div-by-zero
//   -> done high in cycle 1. Fixed latency; no early-out for zero operands.
//  start while busy (RUN/DONE) is ignored, no queuing; start in the DONE->IDLE cycle is not
//   accepted (next acceptance one cycle later). op/operand changes after acceptance have no effect.
//  ALU outputs change only in RUN; alu_out must settle within one cycle (combinational ALU).
// TESTING
//  MUL 7*6, start pulse -> done exactly 33 cycles later, result=42; busy high cycles 1..33.
//  MUL/MULHU 32'hFFFFFFFF*32'hFFFFFFFF -> MUL result=32'h00000001, MULHU result=32'hFFFFFFFE.
//  DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 32'hFFFFFFFF/1 -> 32'hFFFFFFFF, REMU -> 0.
//  DIVU 5/0 -> done 1 cycle after start, result=32'hFFFFFFFF; REMU 5/0 -> result=5; ALU idle.
//  start held high with new operands during RUN -> ignored, first result unchanged; back-to-back ok.
//  rst_n low at RUN cycle 10 -> busy/done/result/ALU outputs 0 immediately; new start runs clean.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle unsigned MUL/MULHU/DIVU/REMU controller sharing the datapath ALU
//   i_clk, i_rst_n (async active-low)     clock and reset
//   i_start, i_op, i_operand_a/b           request, op (00 MUL 01 MULHU 10 DIVU 11 REMU), operands
//   o_busy, o_done, o_result               status, one-cycle done pulse, held result
//   o_alu_src_a/b, o_alu_control           drive the shared ALU, i_alu_out is its combinational result
module mdu_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] ALU_ADD = 3'b000,
    parameter logic [2:0] ALU_SUB = 3'b001
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_alu_src_a,
    output logic [WIDTH-1:0] o_alu_src_b,
    output logic [2:0]       o_alu_control,
    input  logic [WIDTH-1:0] i_alu_out
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
    // r_hi/r_lo hold {hi,lo} for multiply and {r,q} for divide; r_m is multiplicand or divisor
    logic [1:0]       r_state, r_op;
    logic [WIDTH-1:0] r_hi, r_lo, r_m, r_result;
    logic [4:0]       r_cnt;
    logic             w_run, w_mul, w_carry, w_ge, w_dz;
    logic [WIDTH-1:0] w_sum, w_shl, w_hi_nx, w_lo_nx;
    assign w_run   = r_state == S_RUN;
    assign w_mul   = ~r_op[1];
    assign w_shl   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_sum   = r_lo[0] ? i_alu_out : r_hi;
    // a 32-bit add overflowed exactly when the sum wrapped below an operand
    assign w_carry = r_lo[0] & (i_alu_out < r_hi);
    // r_hi[31] is the 33rd bit of the shifted remainder, so the subtract always fits
    assign w_ge    = r_hi[WIDTH-1] | (w_shl >= r_m);
    assign w_hi_nx = w_mul ? {w_carry, w_sum[WIDTH-1:1]} : (w_ge ? i_alu_out : w_shl);
    assign w_lo_nx = w_mul ? {w_sum[0], r_lo[WIDTH-1:1]} : {r_lo[WIDTH-2:0], w_ge};
    assign w_dz    = i_op[1] & (i_operand_b == '0);
    assign o_busy        = r_state != S_IDLE;
    assign o_done        = r_state == S_DONE;
    assign o_result      = r_result;
    assign o_alu_src_a   = w_run ? (w_mul ? r_hi : w_shl) : '0;
    assign o_alu_src_b   = w_run ? r_m : '0;
    assign o_alu_control = (w_run && !w_mul) ? ALU_SUB : ALU_ADD;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_op    <= i_op;
                    r_hi    <= '0;
                    r_lo    <= i_op[1] ? i_operand_a : i_operand_b;
                    r_m     <= i_op[1] ? i_operand_b : i_operand_a;
                    r_cnt   <= '0;
                    r_state <= w_dz ? S_DONE : S_RUN;
                    // divide by zero skips the ALU: quotient all ones, remainder is the dividend
                    if (w_dz) r_result <= i_op[0] ? i_operand_a : '1;
                end
                S_RUN: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state  <= S_DONE;
                        r_result <= r_op[0] ? w_hi_nx : w_lo_nx;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer with an arithmetic reference model and ALU model
module tb_mdu_sequencer;
    logic        clk = 0, rst_n = 0, start = 0;
    logic [1:0]  op = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, done;
    logic [31:0] result, src_a, src_b, alu_out;
    logic [2:0]  ctl;
    int          checks = 0, failures = 0, cyc = 0;
    logic [1:0]  n_op;
    logic [31:0] n_a, n_b;
    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign alu_out = (ctl == 3'b000) ? src_a + src_b : (ctl == 3'b001) ? src_a - src_b : 32'h0;

    mdu_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_operand_a(a), .i_operand_b(b), .o_busy(busy), .o_done(done),
        .o_result(result), .o_alu_src_a(src_a), .o_alu_src_b(src_b),
        .o_alu_control(ctl), .i_alu_out(alu_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p = {32'h0, x} * {32'h0, y};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (y == 0) ? 32'hFFFFFFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (rst_n && done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("latency", cyc, e.at);
            end
        end
    end

    // called at an idle point (#1 after a negedge); returns at the next idle point
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit hold, input bit chain, input int rst_at);
        logic [31:0] e = model(o, x, y);
        bit          dz = o[1] && (y == 0);
        chk("idle_busy", busy, 0);
        start = 1; op = o; a = x; b = y;
        sb.push_back('{e, cyc + (dz ? 1 : 33)});
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk); #1;
            if (n == rst_at) begin
                rst_n = 0; start = 0; #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_result", result, 0);
                chk("rst_src_a", src_a, 0);
                chk("rst_src_b", src_b, 0);
                chk("rst_ctl", ctl, 0);
                sb.delete();
                @(negedge clk); #1;
                rst_n = 1;
                return;
            end
            chk("busy", busy, 1);
            if (dz) chk("dz_alu_idle", src_a | src_b | 32'(ctl), 0);
            if (n == 1 && !dz) chk("alu_ctl", ctl, o[1] ? 1 : 0);
            if (done) begin
                start = chain;
                if (chain) begin op = n_op; a = n_a; b = n_b; end
                @(negedge clk); #1;
                chk("result_held", result, e);
                chk("idle_after_done", busy, 0);
                return;
            end
            if (hold) begin op = 2'($urandom); a = $urandom; b = $urandom; end
            else start = 0;
        end
        chk("timeout", 1, 0);
        start = 0;
    endtask

    initial begin
        @(negedge clk); #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_alu", src_a | src_b | 32'(ctl), 0);
        rst_n = 1;
        issue(2'd0, 32'd7, 32'd6, 0, 0, 0);
        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        issue(2'd2, 32'd100, 32'd7, 0, 0, 0);
        issue(2'd3, 32'd100, 32'd7, 0, 0, 0);
        issue(2'd2, 32'hFFFFFFFF, 32'd1, 0, 0, 0);
        issue(2'd3, 32'hFFFFFFFF, 32'd1, 0, 0, 0);
        issue(2'd2, 32'd5, 32'd0, 0, 0, 0);
        issue(2'd3, 32'd5, 32'd0, 0, 0, 0);
        issue(2'd0, 32'd123, 32'd456, 1, 0, 0);
        n_op = 2'd3; n_a = $urandom; n_b = $urandom | 32'h1;
        issue(2'd1, $urandom, $urandom, 0, 1, 0);
        issue(n_op, n_a, n_b, 0, 0, 0);
        issue(2'd2, $urandom, $urandom_range(1, 1000), 0, 0, 10);
        issue(2'd0, 32'd3, 32'd5, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  o = 2'($urandom_range(0, 3));
            logic [31:0] x = $urandom;
            logic [31:0] y = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            issue(o, x, y, bit'($urandom_range(0, 1)), 0, 0);
        end
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
